// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - encodes RISC-V style instructions into a one-entry holding register and writes them to memory
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    logic        hold_valid;
    logic        accept;
    logic        done;
    logic        legal;
    logic [31:0] enc;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // A value fits when every bit above the field's sign bit copies it
    assign fits12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fits13 = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
    assign fits21 = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];

    always_comb begin
        enc   = '0;
        legal = 1'b0;
        case (req_fmt)
            3'd0: begin
                enc   = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
                legal = fits12;
            end
            3'd1: begin
                enc   = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_ALU};
                legal = fits12;
            end
            3'd2: begin
                enc   = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_S};
                legal = fits12;
            end
            3'd3: begin
                enc   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], OP_B};
                legal = fits13;
            end
            3'd4: begin
                enc   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_J};
                legal = fits21;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign req_ready = reset_n && !clear && (!hold_valid || mem_ready);
    assign accept    = req_valid && req_ready;
    assign done      = hold_valid && mem_ready;
    assign mem_we    = hold_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            err        <= 1'b0;
            err_count  <= '0;
        end else if (clear) begin
            // clear wins over a completing write and any request on this edge
            hold_valid <= 1'b0;
            mem_addr   <= BASE;
        end else begin
            if (done) begin
                mem_addr <= mem_addr + ADDR_W'(4);
            end
            if (accept && legal) begin
                hold_valid <= 1'b1;
                mem_wdata  <= enc;
            end else if (done) begin
                hold_valid <= 1'b0;
            end
            if (accept && !legal) begin
                err <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder against a queue-based behavioural model
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic [7:0]  err_count;

    logic        req_valid2;
    logic        req_ready2;
    logic        mem_we2;
    logic [3:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic        err2;
    logic [7:0]  err_count2;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_imm(req_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .err(err), .err_count(err_count)
    );

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_fmt(req_fmt), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_imm(req_imm),
        .mem_we(mem_we2), .mem_ready(1'b1), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .err(err2), .err_count(err_count2)
    );

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] imm;
    } entry_t;

    entry_t      q[$];
    int          wcount = 0;
    int          errs   = 0;
    logic [31:0] log_data[$];
    int          log_addr[$];
    int          log_cyc[$];
    int          log2_addr[$];
    logic        model_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] opcode_of(input logic [2:0] f);
        case (f)
            3'd0:    return 7'h03;
            3'd1:    return 7'h13;
            3'd2:    return 7'h23;
            3'd3:    return 7'h63;
            default: return 7'h6F;
        endcase
    endfunction

    function automatic bit model_legal(input logic [2:0] f, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (f)
            3'd0, 3'd1, 3'd2: return v >= -2048 && v <= 2047;
            3'd3:             return v >= -4096 && v <= 4095 && (v % 2 == 0);
            3'd4:             return v >= -1048576 && v <= 1048575 && (v % 2 == 0);
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [31:0] imm);
        logic [31:0] r;
        r = 32'(opcode_of(f));
        case (f)
            3'd0, 3'd1:
                r |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            3'd2:
                r |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
            3'd3:
                r |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            default:
                r |= (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (32'(rd) << 7);
        endcase
        return r;
    endfunction

    // Recovers the sign-extended immediate from an encoded word by its opcode
    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        case (w[6:0])
            7'h03, 7'h13: return {{20{w[31]}}, w[31:20]};
            7'h23:        return {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63:        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default:      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            wcount = 0;
            errs   = 0;
            chk("rst_we", {31'd0, mem_we}, 32'd0);
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
        end else begin
            model_ready = !clear && (q.size() == 0 || mem_ready);
            chk("req_ready", {31'd0, req_ready}, {31'd0, model_ready});
            chk("mem_we", {31'd0, mem_we}, {31'd0, q.size() != 0});
            chk("mem_addr", {22'd0, mem_addr}, 32'((wcount * 4) % 1024));
            if (q.size() != 0) begin
                chk("mem_wdata", mem_wdata, q[0].data);
                chk("imm_decode", decode_imm(mem_wdata), q[0].imm);
            end
            chk("err", {31'd0, err}, {31'd0, errs != 0});
            chk("err_count", {24'd0, err_count}, (errs > 255) ? 32'd255 : 32'(errs));
            if (!clear && mem_we && mem_ready) begin
                log_data.push_back(mem_wdata);
                log_addr.push_back(int'(mem_addr));
                log_cyc.push_back(cyc);
            end
            if (!clear && mem_we2) log2_addr.push_back(int'(mem_addr2));
            if (clear) begin
                q.delete();
                wcount = 0;
            end else begin
                if (q.size() != 0 && mem_ready) begin
                    void'(q.pop_front());
                    wcount++;
                end
                if (req_valid && model_ready) begin
                    if (model_legal(req_fmt, req_imm))
                        q.push_back('{model_enc(req_fmt, req_rd, req_rs1, req_rs2, req_funct3, req_imm),
                                      req_imm});
                    else
                        errs++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        bit ok;
        ok = 1'b0;
        req_fmt = f; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_funct3 = f3; req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        req_valid = 1'b0;
        nchecks++;
        if (!ok) begin
            nfail++;
            $display("FAIL send_timeout: request fmt %0d never accepted", f);
        end
    endtask

    logic [31:0] held_data;
    logic [9:0]  held_addr;
    int          nlog;

    initial begin
        reset_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; mem_ready = 1'b1;
        req_fmt = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_funct3 = '0; req_imm = '0;
        #1;
        chk("reset_we", {31'd0, mem_we}, 32'd0);
        chk("reset_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_errcnt", {24'd0, err_count}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        idle(3);
        reset_n = 1'b1;
        idle(1);

        send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 32'hFFFFFFFC);
        chk("t039_we_next", {31'd0, mem_we}, 32'd1);
        idle(1);
        chk("t039_we_once", {31'd0, mem_we}, 32'd0);
        idle(2);
        chk("t039_data", log_data[0], 32'hFFC12283);
        chk("t039_addr", 32'(log_addr[0]), 32'd0);

        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8);
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 32'h800);
        idle(3);
        chk("t040_data0", log_data[1], 32'h00208463);
        chk("t040_addr0", 32'(log_addr[1]), 32'd0);
        chk("t040_data1", log_data[2], 32'h001000EF);
        chk("t040_addr1", 32'(log_addr[2]), 32'd4);
        chk("t040_b2b", 32'(log_cyc[2] - log_cyc[1]), 32'd1);

        send(3'd1, 5'd1, 5'd1, 5'd0, 3'b000, 32'd2048);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 32'd3);
        send(3'd6, 5'd1, 5'd1, 5'd1, 3'b000, 32'd0);
        idle(2);
        chk("t041_err", {31'd0, err}, 32'd1);
        chk("t041_errcnt", {24'd0, err_count}, 32'd3);
        chk("t041_addr", {22'd0, mem_addr}, 32'd8);
        chk("t041_nowrite", 32'(log_data.size()), 32'd3);

        mem_ready = 1'b0;
        send(3'd1, 5'd3, 5'd4, 5'd0, 3'b000, 32'd100);
        held_data = mem_wdata;
        held_addr = mem_addr;
        req_fmt = 3'd2; req_rs1 = 5'd6; req_rs2 = 5'd7; req_funct3 = 3'b010; req_imm = 32'hFFFFFFEC;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t042_ready_low", {31'd0, req_ready}, 32'd0);
            chk("t042_data_stable", mem_wdata, held_data);
            chk("t042_addr_stable", {22'd0, mem_addr}, {22'd0, held_addr});
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        idle(2);
        chk("t042_data0", log_data[3], 32'h06420193);
        chk("t042_addr0", 32'(log_addr[3]), 32'd8);
        chk("t042_data1", log_data[4], 32'hFE732623);
        chk("t042_addr1", 32'(log_addr[4]), 32'd12);

        req_valid2 = 1'b1;
        idle(5);
        req_valid2 = 1'b0;
        idle(3);
        chk("t043_count", 32'(log2_addr.size()), 32'd5);
        chk("t043_a0", 32'(log2_addr[0]), 32'd8);
        chk("t043_a1", 32'(log2_addr[1]), 32'd12);
        chk("t043_a2", 32'(log2_addr[2]), 32'd0);
        chk("t043_a3", 32'(log2_addr[3]), 32'd4);
        chk("t043_a4", 32'(log2_addr[4]), 32'd8);

        mem_ready = 1'b0;
        send(3'd0, 5'd1, 5'd1, 5'd0, 3'b000, 32'd1);
        idle(1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("t044_clr_we", {31'd0, mem_we}, 32'd0);
        chk("t044_clr_addr", {22'd0, mem_addr}, 32'd0);
        mem_ready = 1'b1;
        send(3'd4, 5'd2, 5'd0, 5'd0, 3'b000, 32'hFFFFFFFE);
        idle(2);
        chk("t044_count", 32'(log_data.size()), 32'd6);
        chk("t044_data", log_data[5], 32'hFFFFF16F);
        chk("t044_addr", 32'(log_addr[5]), 32'd0);
        chk("t044_errcnt", {24'd0, err_count}, 32'd3);

        mem_ready = 1'b0;
        send(3'd1, 5'd9, 5'd9, 5'd0, 3'b001, 32'd5);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t044_arst_we", {31'd0, mem_we}, 32'd0);
        chk("t044_arst_addr", {22'd0, mem_addr}, 32'd0);
        chk("t044_arst_wdata", mem_wdata, 32'd0);
        chk("t044_arst_err", {31'd0, err}, 32'd0);
        chk("t044_arst_errcnt", {24'd0, err_count}, 32'd0);
        chk("t044_arst_ready", {31'd0, req_ready}, 32'd0);
        mem_ready = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(3);
        chk("t044_nowrite", 32'(log_data.size()), 32'd6);

        send(3'd0, 5'd31, 5'd31, 5'd0, 3'b111, 32'd2047);
        send(3'd1, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFFF800);
        send(3'd2, 5'd0, 5'd17, 5'd31, 3'b001, 32'd2047);
        send(3'd3, 5'd0, 5'd31, 5'd31, 3'b111, 32'hFFFFF000);
        send(3'd4, 5'd31, 5'd0, 5'd0, 3'b000, 32'h000FFFFE);
        send(3'd4, 5'd3, 5'd0, 5'd0, 3'b000, 32'h00100000);
        idle(3);
        nlog = log_data.size();
        chk("bound_writes", 32'(nlog), 32'd11);
        chk("bound_i_min", log_data[7], 32'h80000013);
        chk("bound_err", {24'd0, err_count}, 32'd1);

        for (int i = 0; i < 260; i++) send(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
        idle(2);
        chk("sat_errcnt", {24'd0, err_count}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the write address.
REQ-002 SHALL have parameter BASE_ADDR, default 0: address of the first write after reset or clear.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 clear  in  1  synchronous restart: address counter and holding register only.
REQ-006 req_valid  in  1  an encode request is present.
REQ-007 req_ready  out  1  the request is accepted on an edge where req_valid && req_ready.
REQ-008 req_fmt  in  3  format: 0=I-load, 1=I-alu, 2=S, 3=B, 4=J; values 5-7 are illegal.
REQ-009 req_rd, req_rs1, req_rs2  in  5 each  register fields.
REQ-010 req_funct3  in  3  funct3 field.
REQ-011 req_imm  in  32  immediate, signed byte value.
REQ-012 mem_we  out  1  write strobe to instruction memory.
REQ-013 mem_ready  in  1  memory accepts the write this cycle.
REQ-014 mem_addr  out  ADDR_W  byte address of the write.
REQ-015 mem_wdata  out  32  encoded instruction.
REQ-016 err  out  1  sticky error flag.
REQ-017 err_count  out  8  count of rejected requests, saturating at 255.

Function
REQ-018 Opcodes SHALL be: I-load 0000011, I-alu 0010011, S 0100011, B 1100011, J 1101111; bits [6:0] always hold the opcode.
REQ-019 I format SHALL place imm[11:0] at [31:20], rs1 at [19:15], funct3 at [14:12] and rd at [11:7].
REQ-020 S format SHALL place imm[11:5] at [31:25], rs2 at [24:20], rs1, funct3, and imm[4:0] at [11:7].
REQ-021 B format SHALL place imm[12] at [31], imm[10:5] at [30:25], rs2, rs1, funct3, imm[4:1] at [11:8], and imm[11] at [7].
REQ-022 J format SHALL place imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12], and rd at [11:7].
REQ-023 Fields unused by a format SHALL be ignored.
REQ-024 Range check, per format:
- I and S: req_imm[31:11] all equal.
- B: req_imm[31:12] all equal and req_imm[0]=0.
- J: req_imm[31:20] all equal and req_imm[0]=0.
REQ-025 A request that is accepted but fails the range check or has an illegal fmt SHALL NOT be written; it sets err and increments err_count.
REQ-026 Holding register (one entry): an accepted legal request is encoded into it on the accepting edge.
REQ-027 mem_we SHALL be high from the next cycle until the edge on which mem_ready is sampled high.
REQ-028 req_ready SHALL be (!hold_valid || mem_ready) && !clear, so that with mem_ready continuously high the block sustains one write per cycle.
REQ-029 mem_wdata and mem_addr SHALL be stable while mem_we && !mem_ready.
REQ-030 After each completed write (mem_we && mem_ready), mem_addr SHALL advance by 4 and wrap modulo 2^ADDR_W.
REQ-031 clear SHALL set mem_addr to BASE_ADDR and drop the holding entry (mem_we low next cycle); it SHALL NOT change err or err_count.
REQ-032 clear has priority over a simultaneous write completion or request: neither takes effect.
REQ-033 When a write completes and a new request is accepted on the same edge, the holding register SHALL take the new entry and the address SHALL advance once.
REQ-034 Invariant: sign-extending the immediate decoded from mem_wdata per its opcode SHALL equal req_imm for every legal request.

Reset
REQ-035 reset_n low SHALL immediately set mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, err_count=0 and empty the holding register.
REQ-036 While reset_n is low, req_ready SHALL be 0.
REQ-037 Reset asserted during a stalled write SHALL discard the entry with no write.
REQ-038 The first request SHALL be accepted no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-039 I-load with rd=5, rs1=2, funct3=010, imm=0xFFFFFFFC -> mem_wdata=0xFFC12283 at mem_addr=0, mem_we high one cycle after acceptance.
REQ-040 B with rs1=1, rs2=2, funct3=000, imm=8, then J with rd=1, imm=0x800, both with mem_ready=1 -> back-to-back writes 0x00208463 @0 and 0x001000EF @4.
REQ-041 I-alu with imm=2048; then B with imm=3; then fmt=6 -> no writes, err=1, err_count=3, mem_addr unchanged.
REQ-042 mem_ready held low for 3 cycles with 2 requests pending:
- req_ready low while the entry is stalled.
- mem_wdata and mem_addr stable.
- Two writes land at consecutive addresses.
REQ-043 ADDR_W=4, 5 writes from BASE_ADDR=8 -> addresses 8, 12, 0, 4, 8.
REQ-044 clear with reset_n high during a stall -> no write, next write at BASE_ADDR, err_count preserved; reset_n low mid-stall -> all outputs at reset values asynchronously.
